// File: rtl/debug_dump_tx.sv
// debug_dump_tx: serializes PC, register file, a data-memory window and an
// XOR checksum into a framed byte stream for the UART TX FIFO.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             dump request pulse (taken in IDLE only)
//   i_pc                program counter, captured on start
//   i_registers_debug   flat register file, reg i at [i*SIZE +: SIZE]
//   o_mem_addr          data-memory debug word index
//   i_mem_data          data-memory read data, one cycle after address
//   o_tx_data/o_tx_wr   byte and write strobe to the TX FIFO
//   i_tx_full           TX FIFO full, gates o_tx_wr combinationally
//   o_busy, o_done      frame in progress / one-cycle completion pulse
module debug_dump_tx #(
  parameter int          SIZE          = 32,
  parameter int          NUM_REGISTERS = 32,
  parameter int          MEM_WORDS     = 16,
  parameter int          ADDR_WIDTH    = 32,
  parameter logic [7:0]  HEADER        = 8'hA5
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [SIZE-1:0]            i_pc,
  input  logic [NUM_REGISTERS*SIZE-1:0] i_registers_debug,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr,
  input  logic [SIZE-1:0]            i_mem_data,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_wr,
  input  logic                       i_tx_full,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int MAXW =
    (NUM_REGISTERS > MEM_WORDS) ? NUM_REGISTERS : MEM_WORDS;
  localparam int CW = (MAXW < 1) ? 1 : $clog2(MAXW + 1);

  localparam logic [CW-1:0] LAST_REG = CW'(NUM_REGISTERS - 1);
  localparam logic [CW-1:0] LAST_MEM =
    (MEM_WORDS > 0) ? CW'(MEM_WORDS - 1) : '0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PC,
    ST_REGS,
    ST_MEM_ADDR,
    ST_MEM_WAIT,
    ST_MEM,
    ST_CSUM,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      byte_q, byte_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [SIZE-1:0] word_q, word_d;
  logic [7:0]      csum_q, csum_d;

  logic [SIZE-1:0] reg_word;
  logic [SIZE-1:0] cur_word;
  logic [7:0]      cur_byte;
  logic            emit;
  logic            wr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
    end
  end

  // Registers are read live; the debugger keeps them stable via stall.
  always_comb begin
    reg_word = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      if (wcnt_q == CW'(i)) begin
        reg_word = i_registers_debug[i*SIZE +: SIZE];
      end
    end
  end

  assign cur_word = (state_q == ST_REGS) ? reg_word : word_q;

  always_comb begin
    unique case (byte_q)
      2'd0:    cur_byte = cur_word[31:24];
      2'd1:    cur_byte = cur_word[23:16];
      2'd2:    cur_byte = cur_word[15:8];
      default: cur_byte = cur_word[7:0];
    endcase
  end

  assign emit = (state_q == ST_HEADER) || (state_q == ST_PC) ||
                (state_q == ST_REGS)   || (state_q == ST_MEM) ||
                (state_q == ST_CSUM);
  assign wr   = emit && !i_tx_full;

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    wcnt_d     = wcnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    o_tx_wr    = wr;
    o_tx_data  = 8'h00;
    o_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    o_done     = 1'b0;
    o_mem_addr = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          word_d  = i_pc;
          csum_d  = '0;
          byte_d  = '0;
          wcnt_d  = '0;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        o_tx_data = HEADER;
        if (wr) state_d = ST_PC;
      end
      ST_PC: begin
        o_tx_data = cur_byte;
        if (wr) begin
          csum_d = csum_q ^ cur_byte;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) state_d = ST_REGS;
        end
      end
      ST_REGS: begin
        o_tx_data = cur_byte;
        if (wr) begin
          csum_d = csum_q ^ cur_byte;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            if (wcnt_q == LAST_REG) begin
              wcnt_d  = '0;
              state_d = (MEM_WORDS == 0) ? ST_CSUM : ST_MEM_ADDR;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
      end
      ST_MEM_ADDR: begin
        o_mem_addr = ADDR_WIDTH'(wcnt_q);
        state_d    = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        o_mem_addr = ADDR_WIDTH'(wcnt_q);
        word_d     = i_mem_data;
        state_d    = ST_MEM;
      end
      ST_MEM: begin
        o_mem_addr = ADDR_WIDTH'(wcnt_q);
        o_tx_data  = cur_byte;
        if (wr) begin
          csum_d = csum_q ^ cur_byte;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            if (wcnt_q == LAST_MEM) begin
              state_d = ST_CSUM;
            end else begin
              wcnt_d  = wcnt_q + 1'b1;
              state_d = ST_MEM_ADDR;
            end
          end
        end
      end
      ST_CSUM: begin
        o_tx_data = csum_q;
        if (wr) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: expected frames are queued by the
// stimulus and popped by a byte monitor on every FIFO write.
module tb_debug_dump_tx;

  logic          i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rst;
  logic          i_start;
  logic          i_tx_full;
  logic [31:0]   i_pc;
  logic [1023:0] regs;
  logic [31:0]   o_mem_addr;
  logic [31:0]   mem_data;
  logic [7:0]    o_tx_data;
  logic          o_tx_wr;
  logic          o_busy;
  logic          o_done;

  logic          start2;
  logic [31:0]   pc2;
  logic [63:0]   regs2;
  logic [31:0]   mem_addr2;
  logic [31:0]   mem_data2;
  logic [7:0]    tx_data2;
  logic          tx_wr2;
  logic          full2;
  logic          busy2;
  logic          done2;

  logic [7:0] q[$];
  logic [7:0] q2[$];
  int n_chk = 0;
  int n_fail = 0;
  int rx_cnt = 0;

  debug_dump_tx dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_start           (i_start),
    .i_pc              (i_pc),
    .i_registers_debug (regs),
    .o_mem_addr        (o_mem_addr),
    .i_mem_data        (mem_data),
    .o_tx_data         (o_tx_data),
    .o_tx_wr           (o_tx_wr),
    .i_tx_full         (i_tx_full),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  debug_dump_tx #(
    .NUM_REGISTERS (2),
    .MEM_WORDS     (0)
  ) dut2 (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_start           (start2),
    .i_pc              (pc2),
    .i_registers_debug (regs2),
    .o_mem_addr        (mem_addr2),
    .i_mem_data        (mem_data2),
    .o_tx_data         (tx_data2),
    .o_tx_wr           (tx_wr2),
    .i_tx_full         (full2),
    .o_busy            (busy2),
    .o_done            (done2)
  );

  // Memory model: word k = A0000000+k, one cycle read latency.
  always @(posedge i_clk) begin
    mem_data <= 32'hA000_0000 + {28'd0, o_mem_addr[3:0]};
  end

  assign mem_data2 = 32'h0;
  assign full2     = 1'b0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Byte monitor for both instances.
  always @(negedge i_clk) begin
    if (o_tx_wr) begin
      rx_cnt++;
      check("wr_while_full", {31'd0, i_tx_full}, 32'd0);
      if (q.size() == 0) begin
        check("extra_byte", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
      end else begin
        check("byte", {24'd0, o_tx_data}, {24'd0, q.pop_front()});
      end
    end
    if (tx_wr2) begin
      if (q2.size() == 0) begin
        check("extra_byte2", {24'd0, tx_data2}, 32'hFFFF_FFFF);
      end else begin
        check("byte2", {24'd0, tx_data2}, {24'd0, q2.pop_front()});
      end
    end
  end

  task automatic push_frame(input logic [31:0] pc, input int nr,
                            input int mw, input bit sec);
    logic [7:0]  fr[$];
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    fr.push_back(8'hA5);
    for (int i = 0; i < 1 + nr + mw; i++) begin
      if (i == 0)       w = pc;
      else if (i <= nr) w = 32'h0101_0101 * (i - 1);
      else              w = 32'hA000_0000 + (i - 1 - nr);
      for (int b = 3; b >= 0; b--) begin
        fr.push_back(w[8*b +: 8]);
        cs ^= w[8*b +: 8];
      end
    end
    fr.push_back(cs);
    foreach (fr[j]) begin
      if (sec) q2.push_back(fr[j]);
      else     q.push_back(fr[j]);
    end
  endtask

  // Slot walk: emitting slots stall on full cycles, fetch slots never do.
  function automatic int exp_done(input bit bp, input int nr, input int mw);
    int c;
    c = 1;
    for (int s = 0; s < 5 + 4 * nr; s++) begin
      while (bp && (c % 2 == 1)) c++;
      c++;
    end
    for (int k = 0; k < mw; k++) begin
      c += 2;
      for (int b = 0; b < 4; b++) begin
        while (bp && (c % 2 == 1)) c++;
        c++;
      end
    end
    while (bp && (c % 2 == 1)) c++;
    c++;
    return c;
  endfunction

  task automatic run_frame(input bit bp, input bit rs, input bit chk,
                           output int dc);
    dc = -1;
    @(posedge i_clk); #1;
    i_start   = 1'b1;
    i_tx_full = 1'b0;
    for (int c = 1; c < 2000; c++) begin
      @(posedge i_clk); #1;
      i_start   = rs && (c == 50);
      i_tx_full = bp && (c % 2 == 1);
      @(negedge i_clk);
      if (chk && c >= 134 && c < 230)
        check("mem_addr", o_mem_addr, (c - 134) / 6);
      if (chk && c == 230) begin
        check("csum_wr", {31'd0, o_tx_wr}, 32'd1);
        check("csum_val", {24'd0, o_tx_data}, 32'h40);
      end
      if (o_done) begin
        dc = c;
        break;
      end
    end
    if (dc < 0) check("timeout", 32'd0, 32'd1);
    check("busy_at_done", {31'd0, o_busy}, 32'd0);
    i_start   = 1'b0;
    i_tx_full = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    int dc;
    int ndone;
    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_tx_full = 1'b0;
    i_pc      = 32'h0000_0040;
    start2    = 1'b0;
    pc2       = 32'h1234_5678;
    regs2     = {32'h0101_0101, 32'h0000_0000};
    for (int i = 0; i < 32; i++) regs[i*32 +: 32] = 32'h0101_0101 * i;

    idle_cycles(3);
    @(negedge i_clk);
    check("rst_tx_wr", {31'd0, o_tx_wr}, 32'd0);
    check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    i_rst = 1'b0;
    idle_cycles(2);

    // Basic dump.
    push_frame(32'h40, 32, 16, 1'b0);
    rx_cnt = 0;
    run_frame(1'b0, 1'b0, 1'b1, dc);
    check("done_cycle", dc, 231);
    idle_cycles(20);
    check("bytes_basic", rx_cnt, 198);
    check("queue_basic", q.size(), 0);

    // Back-pressure on odd cycles.
    push_frame(32'h40, 32, 16, 1'b0);
    rx_cnt = 0;
    run_frame(1'b1, 1'b0, 1'b0, dc);
    check("done_cycle_bp", dc, exp_done(1'b1, 32, 16));
    idle_cycles(20);
    check("bytes_bp", rx_cnt, 198);
    check("queue_bp", q.size(), 0);

    // Second start while busy is dropped.
    push_frame(32'h40, 32, 16, 1'b0);
    rx_cnt = 0;
    run_frame(1'b0, 1'b1, 1'b0, dc);
    check("done_cycle_rs", dc, 231);
    idle_cycles(40);
    check("bytes_rs", rx_cnt, 198);
    check("busy_after_rs", {31'd0, o_busy}, 32'd0);

    // Reset mid-frame.
    push_frame(32'h40, 32, 16, 1'b0);
    @(posedge i_clk); #1;
    i_start = 1'b1;
    for (int c = 1; c <= 101; c++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      i_rst   = (c == 100);
      @(negedge i_clk);
      if (c == 101) begin
        check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        check("rst_mid_wr", {31'd0, o_tx_wr}, 32'd0);
      end
    end
    q.delete();
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_done) ndone++;
    end
    check("rst_mid_no_done", ndone, 0);
    push_frame(32'h40, 32, 16, 1'b0);
    rx_cnt = 0;
    run_frame(1'b0, 1'b0, 1'b1, dc);
    check("done_cycle_after_rst", dc, 231);
    idle_cycles(10);
    check("bytes_after_rst", rx_cnt, 198);

    // Small instance: two registers, no memory window.
    push_frame(pc2, 2, 0, 1'b1);
    dc = -1;
    @(posedge i_clk); #1;
    start2 = 1'b1;
    for (int c = 1; c < 60; c++) begin
      @(posedge i_clk); #1;
      start2 = 1'b0;
      @(negedge i_clk);
      if (c == 14) begin
        check("small_csum_wr", {31'd0, tx_wr2}, 32'd1);
        check("small_csum", {24'd0, tx_data2}, 32'h08);
      end
      if (done2) begin
        dc = c;
        break;
      end
    end
    check("small_done", dc, 15);
    check("small_done_model", dc, exp_done(1'b0, 2, 0));
    idle_cycles(5);
    check("small_queue", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
